// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the multiply/divide execute unit: op codes and FSM states.
// MULDIV_WORD_OP_EN widens the op code to 4 bits and adds the RV64 word ops.
package exu_muldiv_pkg;

`ifdef MULDIV_WORD_OP_EN
    localparam int unsigned MULDIV_OP_W = 4;
`else
    localparam int unsigned MULDIV_OP_W = 3;
`endif

    typedef logic [MULDIV_OP_W-1:0] muldiv_op_t;

    // Low three bits follow the RV funct3 encoding of the M extension.
    localparam muldiv_op_t OpMul    = muldiv_op_t'(0);
    localparam muldiv_op_t OpMulh   = muldiv_op_t'(1);
    localparam muldiv_op_t OpMulhsu = muldiv_op_t'(2);
    localparam muldiv_op_t OpMulhu  = muldiv_op_t'(3);
    localparam muldiv_op_t OpDiv    = muldiv_op_t'(4);
    localparam muldiv_op_t OpDivu   = muldiv_op_t'(5);
    localparam muldiv_op_t OpRem    = muldiv_op_t'(6);
    localparam muldiv_op_t OpRemu   = muldiv_op_t'(7);
`ifdef MULDIV_WORD_OP_EN
    localparam muldiv_op_t OpMulw   = muldiv_op_t'(8);
    localparam muldiv_op_t OpDivw   = muldiv_op_t'(12);
    localparam muldiv_op_t OpDivuw  = muldiv_op_t'(13);
    localparam muldiv_op_t OpRemw   = muldiv_op_t'(14);
    localparam muldiv_op_t OpRemuw  = muldiv_op_t'(15);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step on the shared {hi, lo} register: shift-add for multiply,
// shift-subtract (restoring) for divide. Purely combinational.
module muldiv_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            ge;

    always_comb begin
        sum     = {1'b0, hi_i} + ({1'b0, opnd_i} & {(XLEN+1){lo_i[0]}});
        shifted = {hi_i, lo_i[XLEN-1]};
        ge      = shifted >= {1'b0, opnd_i};
        // Partial remainder stays below the divisor, so the low XLEN bits suffice.
        sub     = shifted[XLEN-1:0] - opnd_i;
        if (is_div_i) begin
            hi_o = ge ? sub : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ge};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exu_muldiv.sv
// Multi-cycle RV64M multiply/divide unit: FSM, counter, handshakes and sign fix-up.
// Define MULDIV_WORD_OP_EN to add MULW, DIVW, DIVUW, REMW and REMUW.
module exu_muldiv
    import exu_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MULDIV_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]        operand1_i,
    input  logic [XLEN-1:0]        operand2_i,
    input  logic                   wena_i,
    input  logic [REG_ADDR_W-1:0]  waddr_i,
    input  logic                   flush_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        result_o,
    output logic                   wena_o,
    output logic [REG_ADDR_W-1:0]  waddr_o,
    output logic                   busy_o
);

    localparam int unsigned    CW      = $clog2(XLEN);
    localparam logic [CW-1:0]  CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMin   = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_WORD_OP_EN
    localparam logic [CW-1:0]   CntLastW = CW'(31);
    localparam logic [XLEN-1:0] WMin     = {{(XLEN-31){1'b1}}, 31'b0};
    logic [31:0] word_res;
    logic        is_word;
`endif

    muldiv_state_e state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_last;
    muldiv_op_t            op_q, op_d, op;
    logic [XLEN-1:0]       a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  wena_q, wena_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;

    logic            is_mul, is_div, is_rem, sgn_a, sgn_b, neg_a, neg_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a, b, a_ext, b_ext, min_ext, mag_a, mag_b, rem_a;
    logic [XLEN-1:0] iter_opnd, lo_init, spec_res, hi_n, lo_n, quo, rem, res_calc;
    logic [2*XLEN-1:0] prod;

    // In IDLE decode the offered op so special cases resolve at the accept edge.
    always_comb begin
        op      = (state_q == StIdle) ? op_i : op_q;
        a       = (state_q == StIdle) ? operand1_i : a_q;
        b       = (state_q == StIdle) ? operand2_i : b_q;
        is_mul  = op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
        is_div  = op inside {OpDiv, OpDivu, OpRem, OpRemu};
        is_rem  = op inside {OpRem, OpRemu};
        sgn_a   = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        sgn_b   = op inside {OpMulh, OpDiv, OpRem};
        a_ext   = a;
        b_ext   = b;
        rem_a   = a;
        min_ext = XMin;
        cnt_last = CntLast;
`ifdef MULDIV_WORD_OP_EN
        is_word = op inside {OpMulw, OpDivw, OpDivuw, OpRemw, OpRemuw};
        is_mul  = is_mul | (op == OpMulw);
        is_div  = is_div | (op inside {OpDivw, OpDivuw, OpRemw, OpRemuw});
        is_rem  = is_rem | (op inside {OpRemw, OpRemuw});
        sgn_a   = sgn_a | (op inside {OpDivw, OpRemw});
        sgn_b   = sgn_b | (op inside {OpDivw, OpRemw});
        if (is_word) begin
            a_ext    = {{(XLEN-32){sgn_a & a[31]}}, a[31:0]};
            b_ext    = {{(XLEN-32){sgn_b & b[31]}}, b[31:0]};
            rem_a    = {{(XLEN-32){a[31]}}, a[31:0]};
            min_ext  = WMin;
            cnt_last = CntLastW;
        end
`endif
        neg_a     = sgn_a & a_ext[XLEN-1];
        neg_b     = sgn_b & b_ext[XLEN-1];
        mag_a     = neg_a ? -a_ext : a_ext;
        mag_b     = neg_b ? -b_ext : b_ext;
        div_zero  = is_div & (b_ext == '0);
        div_ovf   = is_div & sgn_a & sgn_b & (a_ext == min_ext) & (b_ext == '1);
        spec_res  = div_zero ? (is_rem ? rem_a : '1) : (is_rem ? '0 : a_ext);
        iter_opnd = is_div ? mag_b : mag_a;
        lo_init   = is_div ? mag_a : mag_b;
`ifdef MULDIV_WORD_OP_EN
        // Word divides shift the dividend out of the top, so park it there.
        if (is_word && is_div) lo_init = mag_a << (XLEN - 32);
`endif
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .is_div_i (is_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (iter_opnd),
        .hi_o     (hi_n),
        .lo_o     (lo_n)
    );

    always_comb begin
        prod = {hi_n, lo_n};
        if (neg_a ^ neg_b) prod = -prod;
        quo = (neg_a ^ neg_b) ? -lo_n : lo_n;
        rem = neg_a ? -hi_n : hi_n;
        if (is_div)             res_calc = is_rem ? rem : quo;
        else if (op == OpMul)   res_calc = prod[XLEN-1:0];
        else                    res_calc = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_WORD_OP_EN
        word_res = is_div ? res_calc[31:0] : prod[XLEN-1 -: 32];
        if (is_word) res_calc = {{(XLEN-32){word_res[31]}}, word_res};
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        wena_d   = wena_q;
        waddr_d  = waddr_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush_i) begin
                    op_d    = op_i;
                    a_d     = operand1_i;
                    b_d     = operand2_i;
                    wena_d  = wena_i;
                    waddr_d = waddr_i;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = lo_init;
                    if (!(is_mul || is_div)) begin
                        result_d = '0;
                        state_d  = StDone;
                    end else if (div_zero || div_ovf) begin
                        result_d = spec_res;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == cnt_last) begin
                        cnt_d    = '0;
                        result_d = res_calc;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (flush_i || out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            wena_q   <= 1'b0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            wena_q   <= wena_d;
            waddr_q  <= waddr_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy_o    = (state_q != StIdle);
    assign result_o  = result_q;
    assign wena_o    = wena_q;
    assign waddr_o   = waddr_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: arithmetic vectors, latency, backpressure, flush and reset.
// Word-op vectors are included when MULDIV_WORD_OP_EN is defined.
module tb_exu_muldiv;
    import exu_muldiv_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    muldiv_op_t       op_i;
    logic [XLEN-1:0]  operand1_i;
    logic [XLEN-1:0]  operand2_i;
    logic             wena_i;
    logic [RW-1:0]    waddr_i;
    logic             flush_i;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result_o;
    logic             wena_o;
    logic [RW-1:0]    waddr_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int vec_id   = 0;

    always #5 clk = ~clk;

    exu_muldiv #(
        .XLEN       (XLEN),
        .REG_ADDR_W (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_i       (op_i),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .wena_i     (wena_i),
        .waddr_i    (waddr_i),
        .flush_i    (flush_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_o   (result_o),
        .wena_o     (wena_o),
        .waddr_o    (waddr_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic we, input logic [RW-1:0] wa);
        op_i       = op;
        operand1_i = a;
        operand2_i = b;
        wena_i     = we;
        waddr_i    = wa;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1; bounded so a stuck unit cannot hang the run.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input muldiv_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res);
        int            lat;
        logic          we;
        logic [RW-1:0] wa;
        vec_id++;
        we = vec_id[0];
        wa = RW'(vec_id * 3 + 1);
        check({tag, "_rdy"}, in_ready, 1'b1);
        offer(op, a, b, we, wa);
        check({tag, "_busy"}, busy_o, 1'b1);
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_wena"}, wena_o, we);
        check({tag, "_waddr"}, waddr_o, wa);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        op_i       = '0;
        operand1_i = '0;
        operand2_i = '0;
        wena_i     = 1'b0;
        waddr_i    = '0;
        flush_i    = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_res", result_o, 64'h0);
        check("rst_wena", wena_o, 1'b0);
        check("rst_waddr", waddr_o, 5'd0);
        check("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7_m3", OpMul, 64'd7, -64'sd3, 65, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_big", OpMul, 64'h1_0000_0001, 64'h1_0000_0001, 65, 64'h0000_0002_0000_0001);
        run_op("mulhu_big", OpMulhu, 64'h1_0000_0001, 64'h1_0000_0001, 65, 64'h1);
        run_op("mulhu_max2", OpMulhu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'h1);
        run_op("mulhu_min2", OpMulhu, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65,
               64'h4000_0000_0000_0000);
        run_op("mulh_m1m1", OpMulh, -64'sd1, -64'sd1, 65, 64'h0);
        run_op("mulhsu_m1_2", OpMulhsu, -64'sd1, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_m7_2", OpDiv, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_m7_2", OpRem, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_7_m2", OpDiv, 64'd7, -64'sd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_7_m2", OpRem, 64'd7, -64'sd2, 65, 64'h1);
        run_op("divu_100_7", OpDivu, 64'd100, 64'd7, 65, 64'd14);
        run_op("remu_100_7", OpRemu, 64'd100, 64'd7, 65, 64'd2);
        run_op("divu_max_1", OpDivu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_5_0", OpDiv, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_5_0", OpRemu, 64'd5, 64'd0, 1, 64'd5);
        run_op("div_ovf", OpDiv, 64'h8000_0000_0000_0000, -64'sd1, 1, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", OpRem, 64'h8000_0000_0000_0000, -64'sd1, 1, 64'h0);
`ifdef MULDIV_WORD_OP_EN
        run_op("divw_4", OpDivw, 64'h1_0000_0010, 64'd4, 33, 64'd4);
        run_op("mulw_sx", OpMulw, 64'h7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("remw_m7_2", OpRemw, 64'hFFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divuw_max", OpDivuw, 64'hFFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divw_ovf", OpDivw, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000);
        run_op("remuw_0", OpRemuw, 64'd5, 64'h1_0000_0000, 1, 64'd5);
        run_op("undef_op", muldiv_op_t'(9), 64'd5, 64'd3, 1, 64'h0);
`endif

        // Backpressure: result and tags held while the consumer stalls.
        out_ready = 1'b0;
        offer(OpDivu, 64'd1000, 64'd3, 1'b1, 5'd17);
        wait_valid(lat);
        check("bp_lat", lat, 65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1'b1);
            check("bp_res", result_o, 64'd333);
            check("bp_waddr", waddr_o, 5'd17);
            check("bp_wena", wena_o, 1'b1);
            check("bp_rdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_rdy", in_ready, 1'b1);

        // Flush partway through CALC discards the op.
        offer(OpMul, 64'd3, 64'd5, 1'b1, 5'd4);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("flush_pre_rdy", in_ready, 1'b0);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_rdy", in_ready, 1'b1);
        check("flush_busy", busy_o, 1'b0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", seen, 1'b0);
        check("flush_res_kept", result_o, 64'd333);

        // Flush in IDLE blocks a simultaneous offer.
        flush_i = 1'b1;
        offer(OpMul, 64'd2, 64'd2, 1'b1, 5'd9);
        flush_i = 1'b0;
        check("flush_idle_busy", busy_o, 1'b0);
        check("flush_idle_rdy", in_ready, 1'b1);

        // Reset mid-CALC clears all outputs.
        offer(OpMulhu, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_res", result_o, 64'h0);
        check("mrst_wena", wena_o, 1'b0);
        check("mrst_waddr", waddr_o, 5'd0);
        check("mrst_busy", busy_o, 1'b0);
        check("mrst_rdy", in_ready, 1'b1);
        run_op("post_rst", OpRemu, 64'd100, 64'd7, 65, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
